rf_wport_arbiter: RTL
=====================

RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, range 1..15: consecutive blocked cycles before a stall request.
REQ-002 SHALL have port i_clk, in, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, in, 1: reset, asynchronous, active-low.
REQ-004 SHALL have i_wb_we, in, 1: pipeline WB write request, already qualified by valid; the pipeline cannot be back-pressured.
REQ-005 SHALL have i_wb_rd, in, 5, and i_wb_data, in, 32: pipeline destination register and data.
REQ-006 SHALL have i_sec_valid, in, 1; i_sec_rd, in, 5; i_sec_data, in, 32: secondary requester (multi-cycle unit) write request.
REQ-007 SHALL have o_sec_ready, out, 1: secondary request accepted on a cycle with i_sec_valid && o_sec_ready.
REQ-008 SHALL have o_rf_we, out, 1; o_rf_rd, out, 5; o_rf_data, out, 32: the register file write port, registered.
REQ-009 SHALL have o_rf_src, out, 1: source of the current o_rf_* write (0 = pipeline, 1 = secondary).
REQ-010 SHALL have o_pending_mask, out, 32: bit r set while a secondary write to xr has not yet reached the RF.
REQ-011 SHALL have o_stall_req, out, 1: request to the pipeline to insert a WB bubble.

Function
REQ-012 SHALL hold a 2-entry FIFO of secondary requests {rd, data}; o_sec_ready = (count < 2), with no push on a full cycle even if a pop occurs in the same cycle.
REQ-013 SHALL treat a pipeline write as active when i_wb_we && i_wb_rd != 0; a pipeline request with rd == 0 is discarded and frees the slot.
REQ-014 SHALL give the pipeline absolute priority: an active pipeline write in cycle N appears on o_rf_* with o_rf_src = 0 in cycle N+1 (latency 1).
REQ-015 SHALL pop the FIFO head in cycle N when count > 0 and no pipeline write is active; the head appears on o_rf_* with o_rf_src = 1 in cycle N+1.
REQ-016 SHALL NOT pop an entry in the same cycle it is pushed (minimum secondary latency 2 cycles from acceptance to o_rf_we).
REQ-017 SHALL pop a head entry with rd == 0 normally, but with o_rf_we = 0 in the following cycle.
REQ-018 SHALL drive o_rf_we = 0 with o_rf_rd, o_rf_data and o_rf_src holding their previous values in any cycle following one with neither an active pipeline write nor a pop.
REQ-019 SHALL preserve FIFO order: entries leave in acceptance order, without reordering or drops other than reset.
REQ-020 SHALL compute o_pending_mask combinationally as the OR of the rd one-hot bits of valid FIFO entries, plus o_rf_rd when o_rf_we && o_rf_src; bit 0 is always 0.
REQ-021 SHALL keep a 4-bit starve counter: +1 each cycle with count > 0 and no pop, saturating at STARVE_LIMIT; cleared on a pop or when count == 0.
REQ-022 SHALL assert o_stall_req = (starve counter == STARVE_LIMIT), from the register only; it deasserts in the cycle after the pop.
REQ-023 SHALL handle a push and pop in the same cycle: count unchanged, the new entry becomes the tail.
REQ-024 SHALL handle a pipeline write and secondary acceptance in the same cycle: both take place; the FIFO does not pop.

Reset
REQ-025 SHALL, while i_rst_n = 0, asynchronously clear the FIFO (count 0) and the starve counter, and drive o_rf_we 0, o_rf_rd 0, o_rf_data 0, o_rf_src 0, o_pending_mask 0, o_stall_req 0, and o_sec_ready 1.
REQ-026 SHALL discard accepted but unwritten secondary entries when reset is asserted mid-operation; the first edge after deassertion behaves as from empty.

Verification
REQ-027 SHALL pass: idle, secondary pushes (rd=5, data=0xA5A5A5A5) at cycle 0 -> cycle 2 o_rf_we=1, rd=5, data=0xA5A5A5A5, src=1; o_pending_mask=0x20 in cycles 1-2, 0 in cycle 3.
REQ-028 SHALL pass: pipeline writes rd=3 every cycle while the secondary pushes rd=7, rd=8 -> only src=0 writes, o_sec_ready=0 after 2 pushes, o_stall_req=1 after 8 blocked cycles; then one pipeline bubble -> rd=7 written, o_stall_req drops the next cycle.
REQ-029 SHALL pass: pipeline i_wb_we=1, rd=0 with FIFO holding rd=9 -> FIFO pops; next cycle o_rf_we=1, rd=9, src=1.
REQ-030 SHALL pass: secondary push rd=0 -> popped, o_rf_we stays 0, o_pending_mask stays 0.
REQ-031 SHALL pass: FIFO full (rd=4, rd=6), i_rst_n low for 1 cycle mid-operation -> all outputs at reset values immediately, no write of rd 4 or 6 afterwards, o_sec_ready=1.
REQ-032 SHALL pass: random pipeline/secondary traffic for 10k cycles -> the scoreboard sees every accepted secondary write exactly once in order and every active pipeline write at latency 1.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
//   Shares the single register-file write port between the pipeline WB stage
//   and a secondary multi-cycle requester. The pipeline always has priority.
//   Secondary writes are buffered in a 2-entry FIFO. If the FIFO head waits
//   too long, a stall request asks the pipeline to insert a WB bubble.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_wb_we/i_wb_rd/i_wb_data   pipeline write request (cannot be back-pressured)
//   i_sec_valid/_rd/_data       secondary write request
//   o_sec_ready                 secondary request accepted when valid && ready
//   o_rf_we/_rd/_data           registered register-file write port
//   o_rf_src                    0 = pipeline write, 1 = secondary write
//   o_pending_mask              registers with a secondary write still in flight
//   o_stall_req                 request for a pipeline WB bubble
// -----------------------------------------------------------------------------
module rf_wport_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_sec_valid,
  input  logic [4:0]  i_sec_rd,
  input  logic [31:0] i_sec_data,
  output logic        o_sec_ready,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data,
  output logic        o_rf_src,
  output logic [31:0] o_pending_mask,
  output logic        o_stall_req
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic        hd_q, hd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        rf_src_q, rf_src_d;

  logic        wb_act, sec_ready, push, pop, tail_idx;
  logic [31:0] mask;

  always_comb begin
    wb_act    = i_wb_we && (i_wb_rd != 5'd0);
    sec_ready = (cnt_q != 2'd2);
    push      = i_sec_valid && sec_ready;
    // Pop decision uses the pre-push count, so a freshly pushed entry never
    // leaves in its own acceptance cycle.
    pop       = (cnt_q != 2'd0) && !wb_act;
    // Push happens only when count < 2, so the tail slot is head + count[0].
    tail_idx  = hd_q ^ cnt_q[0];

    hd_d  = pop ? ~hd_q : hd_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;

    starve_d = starve_q;
    if ((cnt_q == 2'd0) || pop) starve_d = 4'd0;
    else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;

    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    rf_src_d  = rf_src_q;
    if (wb_act) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = i_wb_rd;
      rf_data_d = i_wb_data;
      rf_src_d  = 1'b0;
    end else if (pop) begin
      // An x0 head is consumed like any other entry but never written.
      rf_we_d   = (fifo_rd_q[hd_q] != 5'd0);
      rf_rd_d   = fifo_rd_q[hd_q];
      rf_data_d = fifo_data_q[hd_q];
      rf_src_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_rd_q[0]   <= 5'd0;
      fifo_rd_q[1]   <= 5'd0;
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
      hd_q           <= 1'b0;
      cnt_q          <= 2'd0;
      starve_q       <= 4'd0;
      rf_we_q        <= 1'b0;
      rf_rd_q        <= 5'd0;
      rf_data_q      <= 32'd0;
      rf_src_q       <= 1'b0;
    end else begin
      if (push) begin
        fifo_rd_q[tail_idx]   <= i_sec_rd;
        fifo_data_q[tail_idx] <= i_sec_data;
      end
      hd_q      <= hd_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      rf_src_q  <= rf_src_d;
    end
  end

  // Registers still owed a secondary write: buffered entries plus the one
  // currently on the write port.
  always_comb begin
    mask = 32'd0;
    if (cnt_q == 2'd2) begin
      mask[fifo_rd_q[0]] = 1'b1;
      mask[fifo_rd_q[1]] = 1'b1;
    end else if (cnt_q == 2'd1) begin
      mask[fifo_rd_q[hd_q]] = 1'b1;
    end
    if (rf_we_q && rf_src_q) mask[rf_rd_q] = 1'b1;
    mask[0] = 1'b0;
  end

  assign o_sec_ready    = sec_ready;
  assign o_rf_we        = rf_we_q;
  assign o_rf_rd        = rf_rd_q;
  assign o_rf_data      = rf_data_q;
  assign o_rf_src       = rf_src_q;
  assign o_pending_mask = mask;
  assign o_stall_req    = (starve_q == LIMIT);

endmodule
